// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router control path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package router_pkg;

  // Fixed 3-bit state encoding; all eight codes are named states.
  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  // Header destination address field values.
  localparam logic [1:0] ADDR_0       = 2'd0;
  localparam logic [1:0] ADDR_1       = 2'd1;
  localparam logic [1:0] ADDR_2       = 2'd2;
  localparam logic [1:0] ADDR_INVALID = 2'd3;

  // Pick the per-FIFO flag that belongs to a given address.
  function automatic logic sel_flag(input logic [1:0] addr,
                                    input logic f0,
                                    input logic f1,
                                    input logic f2);
    logic r;
    r = 1'b0;
    case (addr)
      ADDR_0:  r = f0;
      ADDR_1:  r = f1;
      ADDR_2:  r = f2;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/router_fsm.sv
// Control FSM of the 1x3 packet router: address decode and write sequencing.
// Latency: Moore outputs change one clock after the inputs that cause a transition.
// Backpressure: parks in FIFO_FULL_STATE while fifo_full=1 and in WAIT_TILL_EMPTY until the target FIFO drains.
// Build option: define ROUTER_FSM_FULL_STATE_EN to add the full_state strobe output.
module router_fsm
  import router_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] data_in,
  input  logic       pkt_valid,
  input  logic       parity_done,
  input  logic       fifo_full,
  input  logic       low_pkt_valid,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  output logic       busy,
  output logic       detect_add,
  output logic       ld_state,
  output logic       laf_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
`ifdef ROUTER_FSM_FULL_STATE_EN
  output logic       lfd_state,
  output logic       full_state
`else
  output logic       lfd_state
`endif
);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] addr;
  logic       hdr_ok;
  logic       soft_rst_sel;
  logic       empty_sel;
  logic       empty_hdr;

  // A header is accepted only with a live packet and a real destination.
  assign hdr_ok       = pkt_valid && (data_in != ADDR_INVALID);
  // Soft reset and drain status follow the latched destination.
  assign soft_rst_sel = sel_flag(addr, soft_reset_0, soft_reset_1, soft_reset_2);
  assign empty_sel    = sel_flag(addr, empty_0, empty_1, empty_2);
  // During decode the address is not latched yet, so look at the header directly.
  assign empty_hdr    = sel_flag(data_in, empty_0, empty_1, empty_2);

  // State and destination-address registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state <= DECODE_ADDRESS;
      addr  <= ADDR_0;
    end else begin
      state <= state_nxt;
      if ((state == DECODE_ADDRESS) && hdr_ok) begin
        addr <= data_in;
      end
    end
  end

  // Next-state decode; a selected soft reset overrides normal transitions.
  always_comb begin
    state_nxt = state;
    case (state)
      DECODE_ADDRESS: begin
        if (hdr_ok) begin
          state_nxt = empty_hdr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: state_nxt = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full) begin
          state_nxt = FIFO_FULL_STATE;
        end else if (!pkt_valid) begin
          state_nxt = LOAD_PARITY;
        end
      end
      LOAD_PARITY: state_nxt = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        state_nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full) begin
          state_nxt = LOAD_AFTER_FULL;
        end
      end
      LOAD_AFTER_FULL: begin
        if (parity_done) begin
          state_nxt = DECODE_ADDRESS;
        end else if (low_pkt_valid) begin
          state_nxt = LOAD_PARITY;
        end else begin
          state_nxt = LOAD_DATA;
        end
      end
      WAIT_TILL_EMPTY: begin
        if (empty_sel) begin
          state_nxt = LOAD_FIRST_DATA;
        end
      end
      default: state_nxt = DECODE_ADDRESS;
    endcase
    if (soft_rst_sel) begin
      state_nxt = DECODE_ADDRESS;
    end
  end

  // Moore output decode from the current state only.
  always_comb begin
    busy          = 1'b1;
    detect_add    = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    write_enb_reg = 1'b0;
    rst_int_reg   = 1'b0;
    lfd_state     = 1'b0;
`ifdef ROUTER_FSM_FULL_STATE_EN
    full_state    = 1'b0;
`endif
    case (state)
      DECODE_ADDRESS: begin
        busy       = 1'b0;
        detect_add = 1'b1;
      end
      LOAD_FIRST_DATA: lfd_state = 1'b1;
      LOAD_DATA: begin
        busy          = 1'b0;
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
      end
      LOAD_PARITY: write_enb_reg = 1'b1;
      LOAD_AFTER_FULL: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
      end
      CHECK_PARITY_ERROR: rst_int_reg = 1'b1;
`ifdef ROUTER_FSM_FULL_STATE_EN
      FIFO_FULL_STATE: full_state = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: walks every state and transition with hand-computed outputs.
// Latency: each step is one clock; outputs sampled 1 time unit after the rising edge.
// Backpressure: fifo_full and empty_k stimulus exercise the parking states.
module tb_router_fsm;

  logic       clk;
  logic       rstn;
  logic [1:0] data_in;
  logic       pkt_valid, parity_done, fifo_full, low_pkt_valid;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       empty_0, empty_1, empty_2;
  logic       busy, detect_add, ld_state, laf_state, write_enb_reg, rst_int_reg, lfd_state;
  logic       full_state;
  logic [6:0] outs;

  int total = 0;
  int bad   = 0;

  // Expected {busy,detect_add,ld_state,laf_state,write_enb_reg,rst_int_reg,lfd_state} per state.
  localparam logic [6:0] E_DEC  = 7'b0100000;
  localparam logic [6:0] E_LFD  = 7'b1000001;
  localparam logic [6:0] E_LD   = 7'b0010100;
  localparam logic [6:0] E_LP   = 7'b1000100;
  localparam logic [6:0] E_FULL = 7'b1000000;
  localparam logic [6:0] E_LAF  = 7'b1001100;
  localparam logic [6:0] E_WAIT = 7'b1000000;
  localparam logic [6:0] E_CHK  = 7'b1000010;

  assign outs = {busy, detect_add, ld_state, laf_state, write_enb_reg, rst_int_reg, lfd_state};

  router_fsm dut (
    .clk           (clk),
    .rstn          (rstn),
    .data_in       (data_in),
    .pkt_valid     (pkt_valid),
    .parity_done   (parity_done),
    .fifo_full     (fifo_full),
    .low_pkt_valid (low_pkt_valid),
    .soft_reset_0  (soft_reset_0),
    .soft_reset_1  (soft_reset_1),
    .soft_reset_2  (soft_reset_2),
    .empty_0       (empty_0),
    .empty_1       (empty_1),
    .empty_2       (empty_2),
    .busy          (busy),
    .detect_add    (detect_add),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .write_enb_reg (write_enb_reg),
    .rst_int_reg   (rst_int_reg),
`ifdef ROUTER_FSM_FULL_STATE_EN
    .lfd_state     (lfd_state),
    .full_state    (full_state)
`else
    .lfd_state     (lfd_state)
`endif
  );

`ifndef ROUTER_FSM_FULL_STATE_EN
  assign full_state = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    step();
    step();
    total++;
    if (outs !== E_DEC) begin
      $display("FAIL reset_outputs got=%b exp=%b", outs, E_DEC);
      bad++;
    end
    rstn = 1'b0;
  endtask

  task automatic test_basic_packet();
    pkt_valid = 1'b1; data_in = 2'd0; empty_0 = 1'b1;
    step();
    total++;
    if (outs !== E_LFD) begin $display("FAIL basic_lfd got=%b exp=%b", outs, E_LFD); bad++; end
    step();
    total++;
    if (outs !== E_LD) begin $display("FAIL basic_ld got=%b exp=%b", outs, E_LD); bad++; end
    step();
    total++;
    if (outs !== E_LD) begin $display("FAIL basic_ld_hold got=%b exp=%b", outs, E_LD); bad++; end
    pkt_valid = 1'b0;
    step();
    total++;
    if (outs !== E_LP) begin $display("FAIL basic_lp got=%b exp=%b", outs, E_LP); bad++; end
    step();
    total++;
    if (outs !== E_CHK) begin $display("FAIL basic_chk got=%b exp=%b", outs, E_CHK); bad++; end
    step();
    total++;
    if (outs !== E_DEC) begin $display("FAIL basic_dec got=%b exp=%b", outs, E_DEC); bad++; end
  endtask

  task automatic test_wait_empty();
    empty_0 = 1'b0; empty_1 = 1'b0; empty_2 = 1'b0;
    pkt_valid = 1'b1; data_in = 2'd1;
    step();
    total++;
    if (outs !== E_WAIT) begin $display("FAIL wait_enter got=%b exp=%b", outs, E_WAIT); bad++; end
    // Other FIFOs draining, and a changed header, must not release the wait.
    empty_0 = 1'b1; empty_2 = 1'b1; data_in = 2'd0;
    step();
    total++;
    if (outs !== E_WAIT) begin $display("FAIL wait_other_empty got=%b exp=%b", outs, E_WAIT); bad++; end
    empty_1 = 1'b1;
    step();
    total++;
    if (outs !== E_LFD) begin $display("FAIL wait_release got=%b exp=%b", outs, E_LFD); bad++; end
    step();
    total++;
    if (outs !== E_LD) begin $display("FAIL wait_to_ld got=%b exp=%b", outs, E_LD); bad++; end
  endtask

  // Starts in LOAD_DATA (address 1) left by test_wait_empty.
  task automatic test_fifo_full();
    fifo_full = 1'b1;
    step();
    total++;
    if (outs !== E_FULL || full_state !== 1'b1
`ifndef ROUTER_FSM_FULL_STATE_EN
        || 1'b1 == 1'b0
`endif
       ) begin
`ifdef ROUTER_FSM_FULL_STATE_EN
      $display("FAIL full_enter got=%b fs=%b exp=%b fs=1", outs, full_state, E_FULL); bad++;
`else
      if (outs !== E_FULL) begin
        $display("FAIL full_enter got=%b exp=%b", outs, E_FULL); bad++;
      end
`endif
    end
    step();
    total++;
    if (outs !== E_FULL) begin $display("FAIL full_hold got=%b exp=%b", outs, E_FULL); bad++; end
    fifo_full = 1'b0;
    step();
    total++;
    if (outs !== E_LAF) begin $display("FAIL full_laf got=%b exp=%b", outs, E_LAF); bad++; end
    parity_done = 1'b0; low_pkt_valid = 1'b0;
    step();
    total++;
    if (outs !== E_LD) begin $display("FAIL laf_to_ld got=%b exp=%b", outs, E_LD); bad++; end
    fifo_full = 1'b1;
    step();
    fifo_full = 1'b0;
    step();
    total++;
    if (outs !== E_LAF) begin $display("FAIL full_laf2 got=%b exp=%b", outs, E_LAF); bad++; end
    low_pkt_valid = 1'b1;
    step();
    total++;
    if (outs !== E_LP) begin $display("FAIL laf_to_lp got=%b exp=%b", outs, E_LP); bad++; end
    low_pkt_valid = 1'b0;
    step();
    // Parity check with the FIFO full again parks in FIFO_FULL_STATE.
    fifo_full = 1'b1;
    step();
    total++;
    if (outs !== E_FULL) begin $display("FAIL chk_to_full got=%b exp=%b", outs, E_FULL); bad++; end
    fifo_full = 1'b0;
    step();
    parity_done = 1'b1;
    step();
    total++;
    if (outs !== E_DEC) begin $display("FAIL laf_parity_done got=%b exp=%b", outs, E_DEC); bad++; end
    parity_done = 1'b0; pkt_valid = 1'b0;
  endtask

  task automatic test_soft_reset();
    pkt_valid = 1'b1; data_in = 2'd2; empty_2 = 1'b1;
    step();
    step();
    total++;
    if (outs !== E_LD) begin $display("FAIL soft_setup_ld got=%b exp=%b", outs, E_LD); bad++; end
    soft_reset_1 = 1'b1;
    step();
    total++;
    if (outs !== E_LD) begin $display("FAIL soft_other_ignored got=%b exp=%b", outs, E_LD); bad++; end
    soft_reset_1 = 1'b0; soft_reset_2 = 1'b1;
    step();
    total++;
    if (outs !== E_DEC) begin $display("FAIL soft_selected got=%b exp=%b", outs, E_DEC); bad++; end
    soft_reset_2 = 1'b0; pkt_valid = 1'b0;
    step();
  endtask

  task automatic test_invalid_addr();
    pkt_valid = 1'b1; data_in = 2'd3;
    step();
    total++;
    if (outs !== E_DEC) begin $display("FAIL invalid_addr1 got=%b exp=%b", outs, E_DEC); bad++; end
    step();
    total++;
    if (outs !== E_DEC) begin $display("FAIL invalid_addr2 got=%b exp=%b", outs, E_DEC); bad++; end
    pkt_valid = 1'b0;
  endtask

  task automatic test_reset_mid_packet();
    pkt_valid = 1'b1; data_in = 2'd0; empty_0 = 1'b1;
    step();
    step();
    total++;
    if (outs !== E_LD) begin $display("FAIL rstmid_setup got=%b exp=%b", outs, E_LD); bad++; end
    rstn = 1'b1;
    step();
    total++;
    if (outs !== E_DEC || full_state !== 1'b0) begin
      $display("FAIL rstmid_dec got=%b fs=%b exp=%b fs=0", outs, full_state, E_DEC); bad++;
    end
    rstn = 1'b0; pkt_valid = 1'b0;
  endtask

  initial begin
    rstn = 1'b1; data_in = 2'd0; pkt_valid = 1'b0; parity_done = 1'b0;
    fifo_full = 1'b0; low_pkt_valid = 1'b0;
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
    empty_0 = 1'b0; empty_1 = 1'b0; empty_2 = 1'b0;
    test_reset();
    test_basic_packet();
    test_wait_empty();
    test_fifo_full();
    test_soft_reset();
    test_invalid_addr();
    test_reset_mid_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
